// File: rtl/yaw_integrator.sv
// ---------------------------------------------------------------------------
// yaw_integrator
//
// Turns raw signed Z-axis gyro rate samples into a 12-bit circular robot
// heading. A zero-rate offset is first learned by averaging a block of
// samples while the robot sits still. After that, each offset-corrected rate
// sample is integrated while the robot is moving. Optionally, an IR-derived
// correction is blended in.
//
// Parameters
//   FAST_SIM   1: calibrate on 16 samples (shift 4), 0: 2048 samples (shift 11)
//
// Ports
//   clk        system clock, everything on the rising edge
//   rst_n      asynchronous active-low reset
//   strt_cal   one-cycle pulse, start/restart offset calibration
//   vld        one-cycle strobe, yaw_rt valid this cycle
//   yaw_rt     signed 16-bit angular rate sample
//   moving     integrate only while high
//   en_fusion  apply IR correction (only effective while moving)
//   IR_Dtrm    signed 9-bit IR derivative term
//   cal_done   one-cycle pulse when calibration completes
//   rdy        one-cycle pulse when heading has been updated
//   heading    signed 12-bit heading, 0x7FF is 180 degrees CCW
// ---------------------------------------------------------------------------
module yaw_integrator #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cal,
  input  logic        vld,
  input  logic [15:0] yaw_rt,
  input  logic        moving,
  input  logic        en_fusion,
  input  logic [8:0]  IR_Dtrm,
  output logic        cal_done,
  output logic        rdy,
  output logic [11:0] heading
);

  localparam int          CAL_SHIFT = FAST_SIM ? 4 : 11;
  localparam logic [11:0] CAL_LAST  = 12'((1 << CAL_SHIFT) - 1);

  localparam logic [1:0] UNCAL = 2'd0;
  localparam logic [1:0] CAL   = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [1:0]  state;
  logic [11:0] cal_cnt;
  logic [26:0] cal_sum;
  logic [26:0] cal_sum_nxt;
  logic [15:0] offset;

  // Stage 1 registers: corrected rate plus the qualifiers that travel with it.
  logic        s1_vld;
  logic [15:0] yaw_comp;
  logic        s1_moving;
  logic        s1_fusion;
  logic [8:0]  s1_ir;

  // Stage 2: the heading accumulator itself.
  logic [26:0] acc;
  logic [26:0] acc_nxt;

  logic [16:0] yaw_diff;
  logic [15:0] yaw_sat;
  logic [26:0] rate_term;
  logic [26:0] fusion_term;

  assign cal_sum_nxt = cal_sum + {{11{yaw_rt[15]}}, yaw_rt};

  // The difference of two 16-bit signed values needs 17 bits. If the top two
  // bits disagree, the result left the 16-bit range and is clamped to the
  // nearest end instead of wrapping.
  assign yaw_diff = {yaw_rt[15], yaw_rt} - {offset[15], offset};

  always_comb begin
    yaw_sat = yaw_diff[15:0];
    if (yaw_diff[16] != yaw_diff[15]) begin
      yaw_sat = yaw_diff[16] ? 16'h8000 : 16'h7FFF;
    end
  end

  // The IR term is scaled by 8 before it is subtracted. The accumulator wraps
  // freely because heading is a circular quantity.
  assign rate_term   = {{11{yaw_comp[15]}}, yaw_comp};
  assign fusion_term = {{15{s1_ir[8]}}, s1_ir, 3'b000};

  always_comb begin
    acc_nxt = acc;
    if (s1_moving) begin
      acc_nxt = acc + rate_term;
      if (s1_fusion) begin
        acc_nxt = acc + rate_term - fusion_term;
      end
    end
  end

  assign heading = acc[26:15];

  // Control, calibration and the two pipeline stages share one block because
  // strt_cal has to override all of them at once. A restart drops whatever
  // is in stage 1 without touching acc. As a result, heading keeps its old
  // value until the new calibration finishes and acc is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNCAL;
      cal_cnt   <= 12'd0;
      cal_sum   <= 27'd0;
      offset    <= 16'd0;
      cal_done  <= 1'b0;
      rdy       <= 1'b0;
      s1_vld    <= 1'b0;
      yaw_comp  <= 16'd0;
      s1_moving <= 1'b0;
      s1_fusion <= 1'b0;
      s1_ir     <= 9'd0;
      acc       <= 27'd0;
    end else begin
      cal_done <= 1'b0;
      rdy      <= 1'b0;
      s1_vld   <= 1'b0;
      if (strt_cal) begin
        state   <= CAL;
        cal_cnt <= 12'd0;
        cal_sum <= 27'd0;
      end else begin
        case (state)
          CAL: begin
            if (vld) begin
              cal_sum <= cal_sum_nxt;
              cal_cnt <= cal_cnt + 12'd1;
              if (cal_cnt == CAL_LAST) begin
                offset   <= 16'($signed(cal_sum_nxt) >>> CAL_SHIFT);
                acc      <= 27'd0;
                cal_done <= 1'b1;
                state    <= RUN;
              end
            end
          end
          RUN: begin
            if (vld) begin
              s1_vld    <= 1'b1;
              yaw_comp  <= yaw_sat;
              s1_moving <= moving;
              s1_fusion <= en_fusion;
              s1_ir     <= IR_Dtrm;
            end
            if (s1_vld) begin
              acc <= acc_nxt;
              rdy <= 1'b1;
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_yaw_integrator.sv
// ---------------------------------------------------------------------------
// tb_yaw_integrator
//
// Self-checking bench for yaw_integrator (FAST_SIM = 1).
//
// A table of RUN-mode samples is applied back to back. Each entry carries its
// own expected heading, and that expectation is queued when the sample is
// driven. A monitor on the falling edge pops the queue on each rdy and checks
// both the heading and that rdy came exactly two edges after its vld.
// Hand-written sequences cover reset, calibration restart, pipeline flush,
// wrap-around and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_yaw_integrator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt_cal = 1'b0;
  logic        vld = 1'b0;
  logic [15:0] yaw_rt = 16'h0000;
  logic        moving = 1'b0;
  logic        en_fusion = 1'b0;
  logic [8:0]  IR_Dtrm = 9'h000;
  logic        cal_done;
  logic        rdy;
  logic [11:0] heading;

  typedef struct {
    bit          recal;
    logic [15:0] cal_val;
    logic [15:0] yaw;
    bit          mov;
    bit          fus;
    logic [8:0]  ir;
    logic [11:0] exp_heading;
  } vec_t;

  typedef struct {
    int          due;
    logic [11:0] exp_heading;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  int assert_count = 0;
  int fail_count   = 0;
  int rdy_seen     = 0;
  int cyc          = 0;
  bit sb_enable    = 1'b0;

  yaw_integrator #(.FAST_SIM(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cal  (strt_cal),
    .vld       (vld),
    .yaw_rt    (yaw_rt),
    .moving    (moving),
    .en_fusion (en_fusion),
    .IR_Dtrm   (IR_Dtrm),
    .cal_done  (cal_done),
    .rdy       (rdy),
    .heading   (heading)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The scoreboard monitor samples on the falling edge, away from the edge
  // that updates the DUT.
  always @(negedge clk) begin
    if (sb_enable) begin
      if (rdy) begin
        rdy_seen++;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected rdy", 32'(rdy), 32'h0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          checkOutput("rdy latency", 32'(cyc), 32'(e.due));
          checkOutput("heading", 32'(heading), 32'(e.exp_heading));
        end
      end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
        sb_t e;
        e = sb_q.pop_front();
        checkOutput("missing rdy", 32'(rdy), 32'h1);
      end
    end
  end

  function automatic void addRow(input bit recal, input logic [15:0] cal_val,
                                 input logic [15:0] yaw, input bit mov, input bit fus,
                                 input logic [8:0] ir, input logic [11:0] exp_heading);
    vec_t v;
    v.recal       = recal;
    v.cal_val     = cal_val;
    v.yaw         = yaw;
    v.mov         = mov;
    v.fus         = fus;
    v.ir          = ir;
    v.exp_heading = exp_heading;
    vecs.push_back(v);
  endfunction

  // One RUN sample. Its rdy is due two rising edges after the edge that takes it.
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    @(negedge clk);
    strt_cal  = 1'b0;
    vld       = 1'b1;
    yaw_rt    = v.yaw;
    moving    = v.mov;
    en_fusion = v.fus;
    IR_Dtrm   = v.ir;
    e.due         = cyc + 2;
    e.exp_heading = v.exp_heading;
    sb_q.push_back(e);
  endtask

  task automatic runSample(input logic [15:0] yaw, input bit mov, input logic [11:0] exp_heading);
    vec_t v;
    v.recal       = 1'b0;
    v.cal_val     = 16'h0000;
    v.yaw         = yaw;
    v.mov         = mov;
    v.fus         = 1'b0;
    v.ir          = 9'h000;
    v.exp_heading = exp_heading;
    applyStimulus(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld      = 1'b0;
      strt_cal = 1'b0;
    end
  endtask

  task automatic startCal(input bit with_vld);
    @(negedge clk);
    strt_cal = 1'b1;
    vld      = with_vld;
    yaw_rt   = 16'h7FFF;
  endtask

  // moving, en_fusion and IR_Dtrm are set to nonzero values here. They must
  // have no effect while the DUT is calibrating.
  task automatic feedCal(input logic [15:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("cal_done early", 32'(cal_done), 32'h0);
      strt_cal  = 1'b0;
      vld       = 1'b1;
      yaw_rt    = val;
      moving    = 1'b1;
      en_fusion = 1'b1;
      IR_Dtrm   = 9'h0AB;
    end
  endtask

  task automatic finishCal();
    @(negedge clk);
    checkOutput("cal_done", 32'(cal_done), 32'h1);
    vld       = 1'b0;
    moving    = 1'b0;
    en_fusion = 1'b0;
    IR_Dtrm   = 9'h000;
    @(negedge clk);
    checkOutput("cal_done width", 32'(cal_done), 32'h0);
    checkOutput("heading after cal", 32'(heading), 32'h0);
  endtask

  task automatic calibrate(input logic [15:0] val);
    startCal(1'b0);
    feedCal(val, 16);
    finishCal();
  endtask

  initial begin
    #1_000_000;
    fail_count++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rdy_base;

    // Integration on a zero offset: 8 x 0x1000 = 0x8000, so heading reaches 1 on the last sample.
    for (int i = 1; i <= 8; i++)
      addRow(i == 1, 16'h0000, 16'h1000, 1'b1, 1'b0, 9'h000, (i == 8) ? 12'h001 : 12'h000);
    // Not moving: rdy still fires, heading stays put.
    for (int i = 1; i <= 4; i++)
      addRow(1'b0, 16'h0000, 16'h1000, 1'b0, 1'b0, 9'h000, 12'h001);
    // Fusion: IR -256 scaled by 8 and subtracted adds 2048 per sample, 16 samples -> 0x8000.
    for (int i = 1; i <= 16; i++)
      addRow(i == 1, 16'h0000, 16'h0000, 1'b1, 1'b1, 9'h100, (i == 16) ? 12'h001 : 12'h000);
    // Fusion disabled, then fusion enabled but not moving: no correction.
    for (int i = 1; i <= 16; i++)
      addRow(i == 1, 16'h0000, 16'h0000, 1'b1, 1'b0, 9'h100, 12'h000);
    for (int i = 1; i <= 16; i++)
      addRow(i == 1, 16'h0000, 16'h0000, 1'b0, 1'b1, 9'h100, 12'h000);
    // Saturation: offset -32768, 0x7FFF clamps to +32767, then +1 lands exactly on 0x8000.
    addRow(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 9'h000, 12'h000);
    addRow(1'b0, 16'h8000, 16'h8001, 1'b1, 1'b0, 9'h000, 12'h001);
    // Rate and fusion together: 32767 - 2040 = 30727, then +32767 = 63494.
    addRow(1'b1, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 9'h0FF, 12'h000);
    addRow(1'b0, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 9'h0FF, 12'h001);
    // A negative rate goes below zero: acc -4096 reads as heading 0xFFF.
    addRow(1'b1, 16'h0000, 16'hF000, 1'b1, 1'b0, 9'h000, 12'hFFF);
    // Nonzero offset 0x40: 0x1040 samples integrate like 0x1000.
    for (int i = 1; i <= 8; i++)
      addRow(i == 1, 16'h0040, 16'h1040, 1'b1, 1'b0, 9'h000, (i == 8) ? 12'h001 : 12'h000);

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset heading", 32'(heading), 32'h0);
    checkOutput("reset rdy", 32'(rdy), 32'h0);
    checkOutput("reset cal_done", 32'(cal_done), 32'h0);
    rst_n     = 1'b1;
    sb_enable = 1'b1;

    // vld without any calibration is ignored.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("uncal rdy", 32'(rdy), 32'h0);
      vld    = 1'b1;
      yaw_rt = 16'h1000;
      moving = 1'b1;
    end
    idle(3);
    checkOutput("uncal heading", 32'(heading), 32'h0);

    // Calibrate on 0x40, then 100 matching samples give 100 rdy and zero heading.
    $display("[TB] calibration and offset removal");
    calibrate(16'h0040);
    rdy_base = rdy_seen;
    for (int i = 0; i < 100; i++) runSample(16'h0040, 1'b1, 12'h000);
    idle(4);
    checkOutput("rdy count", 32'(rdy_seen - rdy_base), 32'd100);

    // Restart after 10 samples. The sample that arrives together with
    // strt_cal is discarded, so 16 fresh samples are needed.
    $display("[TB] calibration restart");
    startCal(1'b0);
    feedCal(16'h0000, 10);
    startCal(1'b1);
    feedCal(16'h0000, 16);
    finishCal();

    $display("[TB] table of %0d RUN vectors", vecs.size());
    foreach (vecs[i]) begin
      if (vecs[i].recal) begin
        idle(4);
        calibrate(vecs[i].cal_val);
      end
      applyStimulus(vecs[i]);
    end
    idle(4);

    // Flush: a sample in flight when strt_cal arrives never produces rdy. The
    // heading keeps its value until the new calibration completes.
    $display("[TB] pipeline flush on restart");
    calibrate(16'h0000);
    for (int i = 1; i <= 8; i++) runSample(16'h1000, 1'b1, (i == 8) ? 12'h001 : 12'h000);
    idle(4);
    @(negedge clk);
    vld    = 1'b1;
    yaw_rt = 16'h1000;
    moving = 1'b1;
    @(negedge clk);
    vld      = 1'b0;
    strt_cal = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      strt_cal = 1'b0;
      checkOutput("flushed rdy", 32'(rdy), 32'h0);
      checkOutput("held heading", 32'(heading), 32'h1);
    end
    feedCal(16'h0000, 16);
    finishCal();

    // Wrap-around: sample i leaves acc = i*0x4000, heading = i/2. Sample 4095
    // reads 0x7FF and sample 4096 crosses into 0x800.
    $display("[TB] heading wrap-around");
    for (int i = 1; i <= 4095; i++) runSample(16'h4000, 1'b1, 12'((i * 16384) >> 15));
    runSample(16'h4000, 1'b1, 12'h800);
    idle(4);
    checkOutput("wrap heading", 32'(heading), 32'h800);

    // Asynchronous reset while rdy is high mid-cycle.
    $display("[TB] asynchronous reset mid-pipeline");
    sb_enable = 1'b0;
    @(negedge clk);
    vld    = 1'b1;
    yaw_rt = 16'h4000;
    moving = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("rdy before reset", 32'(rdy), 32'h1);
    checkOutput("heading before reset", 32'(heading), 32'h800);
    rst_n = 1'b0;
    #1;
    checkOutput("async heading", 32'(heading), 32'h0);
    checkOutput("async rdy", 32'(rdy), 32'h0);
    checkOutput("async cal_done", 32'(cal_done), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    sb_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post-reset rdy", 32'(rdy), 32'h0);
      vld    = 1'b1;
      yaw_rt = 16'h4000;
    end
    idle(3);
    checkOutput("post-reset heading", 32'(heading), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/yaw_integrator.md
# yaw_integrator

Converts raw signed Z-axis gyro rate samples into a 12-bit robot heading. Sits directly downstream of the inertial-sensor SPI interface, which delivers `yaw_rt` with a one-cycle `vld` strobe. It calibrates a zero-rate offset on command, then integrates offset-corrected rate while the robot is moving. While fusion is enabled it also applies a correction from the IR derivative term. `heading` feeds the navigation/steering logic.

## Interface
- `FAST_SIM`, default 1: 1 → calibration averages 16 samples (shift 4); 0 → 2048 samples (shift 11).
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `strt_cal`  in  1  one-cycle pulse: start (or restart) offset calibration
- `vld`  in  1  one-cycle strobe: `yaw_rt` valid this cycle; may be asserted every cycle
- `yaw_rt`  in  16  signed angular rate sample
- `moving`  in  1  integrate only when high
- `en_fusion`  in  1  apply IR fusion correction, only when `moving` is also high
- `IR_Dtrm`  in  9  signed IR derivative term
- `cal_done`  out  1  one-cycle pulse when calibration completes
- `rdy`  out  1  one-cycle pulse when `heading` has been updated
- `heading`  out  12  signed heading; 0x000 is the original direction, 0x3FF is 90° CCW, 0x7FF is 180° CCW

## Operation
- States: `UNCAL` (reset state), `CAL`, `RUN`.
- `UNCAL`:
  - `vld` is ignored; `rdy` stays 0; `heading` stays 0.
  - `strt_cal` → `CAL`.
- `CAL`:
  - On `strt_cal` entry: clear the sample counter and the 27-bit signed sum.
  - Each `vld`: sum += sign-extended `yaw_rt`; counter += 1.
  - When the Nth sample is accepted:
    - `offset` (16-bit signed) = sum >>> shift, an arithmetic shift that truncates toward −∞.
    - Clear the heading accumulator.
    - Go to `RUN`.
  - `moving`, `en_fusion` and `IR_Dtrm` are ignored in `CAL`; `rdy` stays 0.
- `RUN`, on each accepted `vld`:
  - Stage 1 (register): `yaw_comp` = `yaw_rt` − `offset`, computed at 17 bits and saturated to [−32768, 32767]. Also register `moving`, `en_fusion` and `IR_Dtrm` alongside.
  - Stage 2 (register): `acc` is a 27-bit signed accumulator.
    - If `moving`: acc += sext(`yaw_comp`).
    - If `moving` and `en_fusion`: additionally acc −= sext(`IR_Dtrm`) <<< 3.
    - Addition wraps modulo 2^27, with no saturation; heading is circular.
  - `heading` = acc[26:15].
- `rdy` pulses once per accepted `RUN` sample, whether or not `moving` is high.
- `strt_cal` in any state returns to `CAL` and restarts from zero.
  - This flushes in-flight pipeline stages: no `rdy` is issued for them.
  - `heading` holds its last value until the new calibration completes, then clears to 0.
- `strt_cal` and `vld` in the same cycle: that sample is discarded.

## Timing
- Reset values: `cal_done` = 0, `rdy` = 0, `heading` = 0x000; internal sum, counter, `offset` and `acc` all 0; state `UNCAL`.
- `cal_done`: registered; high for exactly the one cycle following the edge that accepted the Nth calibration sample. `offset` is valid in that same cycle.
- A `vld` during the `cal_done` cycle is a `RUN` sample.
- `RUN` latency: `vld` sampled at edge k. Stage 1 loads at edge k. `acc`, `heading` and `rdy` update at edge k+1, so `rdy` is high during cycle k+1→k+2, coincident with the new `heading`.
- Full throughput: back-to-back `vld` produces back-to-back `rdy`.
- Asynchronous reset mid-calibration or mid-pipeline immediately returns all outputs to their reset values.

## Test plan
- **Reset:** assert `rst_n`=0 mid-`RUN` with `rdy` pending → `heading`=0x000, `rdy`=0, `cal_done`=0 asynchronously; `vld` pulses with no prior `strt_cal` → no `rdy`.
- **Calibration (`FAST_SIM`=1):**
  - Stimulus: `strt_cal`, then 16 `vld` with `yaw_rt`=0x0040.
  - Expected: `cal_done` high exactly one cycle after the 16th.
  - Then 100 `vld` with `yaw_rt`=0x0040, `moving`=1 → 100 `rdy` pulses and `heading` stays 0x000.
  - Restart check: `strt_cal` after the 10th calibration sample → counting restarts, and `cal_done` needs 16 more samples.
- **Integration:**
  - Stimulus: offset 0 (calibrate on zeros), then 8 `vld` with `yaw_rt`=0x1000, `moving`=1.
  - Expected: `heading`=0x001, each `rdy` two edges after its `vld`.
  - Same stimulus with `moving`=0 → `rdy` pulses, `heading` unchanged.
- **Fusion:**
  - Stimulus: offset 0, 16 `vld` with `yaw_rt`=0, `moving`=1, `en_fusion`=1, `IR_Dtrm`=0x100 (−256).
  - Expected: `heading`=0x001.
  - With `en_fusion`=0, or with `moving`=0 and `en_fusion`=1 → `heading`=0x000.
- **Saturation:**
  - Stimulus: calibrate on `yaw_rt`=0x8000 (offset −32768), then one `vld` with `yaw_rt`=0x7FFF.
  - Expected: `acc` increases by exactly 32767, not 65535.
- **Wrap-around:**
  - Stimulus: integrate with `yaw_rt`=0x4000 until `heading`=0x7FF, then one more 0x4000 sample.
  - Expected: `heading`=0x800, with no stall or saturation.
